// File: rtl/mandel_iter_engine.sv
// rtl/mandel_iter_engine.sv - sequential Mandelbrot escape-time engine, one iteration per clock
// Optional abort input enabled by defining MANDEL_ABORT_EN.
module mandel_iter_engine #(
    parameter int W        = 32,
    parameter int FRAC     = 22,
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef MANDEL_ABORT_EN
    input  logic                abort,
`endif
    input  logic signed [W-1:0] c_re,
    input  logic signed [W-1:0] c_im,
    output logic                ready,
    output logic                done,
    output logic                diverged,
    output logic [ITER_W-1:0]   iter_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int PW = 2 * W + 1;
    // Escape threshold 4.0 at the 2*FRAC scale of the squared terms.
    localparam logic signed [PW-1:0] ESC_LIM = {{(PW-1){1'b0}}, 1'b1} << (2 * FRAC + 2);

    logic [1:0]          state_q, state_d;
    logic signed [W-1:0] zr_q, zr_d, zi_q, zi_d;
    logic signed [W-1:0] cre_q, cre_d, cim_q, cim_d;
    logic [ITER_W-1:0]   k_q, k_d;
    logic                diverged_q, diverged_d;
    logic [ITER_W-1:0]   iter_count_q, iter_count_d;

    logic signed [2*W-1:0] p_rr, p_ii, p_ri;
    logic signed [PW-1:0]  mag, diff, dbl;
    logic signed [W-1:0]   zr_upd, zi_upd;
    logic [ITER_W-1:0]     k_inc;
    logic                  abort_req;

`ifdef MANDEL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        p_rr   = zr_q * zr_q;
        p_ii   = zi_q * zi_q;
        p_ri   = zr_q * zi_q;
        mag    = {p_rr[2*W-1], p_rr} + {p_ii[2*W-1], p_ii};
        diff   = {p_rr[2*W-1], p_rr} - {p_ii[2*W-1], p_ii};
        dbl    = {p_ri, 1'b0};
        zr_upd = W'(diff >>> FRAC) + cre_q;
        zi_upd = W'(dbl >>> FRAC) + cim_q;
        k_inc  = k_q + ITER_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        cre_d        = cre_q;
        cim_d        = cim_q;
        k_d          = k_q;
        diverged_d   = diverged_q;
        iter_count_d = iter_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cre_d   = c_re;
                    cim_d   = c_im;
                    zr_d    = '0;
                    zi_d    = '0;
                    k_d     = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (mag > ESC_LIM) begin
                    diverged_d   = 1'b1;
                    iter_count_d = k_q;
                    state_d      = S_DONE;
                end else begin
                    zr_d = zr_upd;
                    zi_d = zi_upd;
                    k_d  = k_inc;
                    if (k_inc == ITER_W'(MAX_ITER)) begin
                        diverged_d   = 1'b0;
                        iter_count_d = ITER_W'(MAX_ITER);
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            zr_q         <= '0;
            zi_q         <= '0;
            cre_q        <= '0;
            cim_q        <= '0;
            k_q          <= '0;
            diverged_q   <= 1'b0;
            iter_count_q <= '0;
        end else begin
            state_q      <= state_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            cre_q        <= cre_d;
            cim_q        <= cim_d;
            k_q          <= k_d;
            diverged_q   <= diverged_d;
            iter_count_q <= iter_count_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign done       = (state_q == S_DONE);
    assign diverged   = diverged_q;
    assign iter_count = iter_count_q;

endmodule
